bms_contactor_ctrl: RTL and testbench

- Downstream consumer of the watchdog's wd_fault and of the cell-monitor fault flags.
- Sequences the HV contactors through precharge, main close and closed, and forces every contactor open on any fault.
- Latches the fault cause. It re-enables only after an explicit clear while all faults are gone, followed by a fresh close request.
- Outputs drive the contactor driver stage and the BMS status register.

---
 rtl/bms_contactor_ctrl.sv | 96 +++++++++
 tb/tb_bms_contactor_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bms_contactor_ctrl.sv
// HV contactor sequencer: precharge -> main close -> closed, with latched fault
// shutdown that needs an explicit clear and a fresh close request to re-arm.
module bms_contactor_ctrl #(
   parameter logic [23:0] PRECHARGE_MIN     = 24'd500000,
   parameter logic [23:0] PRECHARGE_TIMEOUT = 24'd5000000,
   parameter logic [23:0] OVERLAP_CYCLES    = 24'd50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wd_fault,
   input  logic       ov_fault,
   input  logic       uv_fault,
   input  logic       ot_fault,
   input  logic       close_req,
   input  logic       fault_clr,
   input  logic       precharge_ok,
   output logic       precharge_en,
   output logic       main_neg_en,
   output logic       main_pos_en,
   output logic [2:0] state,
   output logic       fault_latched,
   output logic [3:0] fault_code
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PRECHARGE  = 3'd1,
      S_MAIN_CLOSE = 3'd2,
      S_CLOSED     = 3'd3,
      S_FAULT      = 3'd4
   } state_t;

   state_t      st, nxt;
   logic [23:0] cnt;
   logic        close_q;
   logic        any_fault, close_rise, timeout;
   logic [3:0]  fault_bits;

   assign state = st;

   always_comb begin
      any_fault  = wd_fault | ov_fault | uv_fault | ot_fault;
      close_rise = close_req & ~close_q;
      timeout    = (st == S_PRECHARGE) && (cnt == PRECHARGE_TIMEOUT - 24'd1);
      fault_bits = {timeout, ot_fault, ov_fault | uv_fault, wd_fault};
      nxt        = st;
      // Fault/timeout beat a dropped close_req, which beats normal progress.
      if ((st != S_FAULT && any_fault) || timeout)
         nxt = S_FAULT;
      else if (!close_req && (st == S_PRECHARGE || st == S_MAIN_CLOSE || st == S_CLOSED))
         nxt = S_IDLE;
      else begin
         case (st)
            S_IDLE:       if (close_rise) nxt = S_PRECHARGE;
            S_PRECHARGE:  if (precharge_ok && cnt >= PRECHARGE_MIN - 24'd1) nxt = S_MAIN_CLOSE;
            S_MAIN_CLOSE: if (cnt == OVERLAP_CYCLES - 24'd1) nxt = S_CLOSED;
            S_CLOSED:     nxt = S_CLOSED;
            S_FAULT:      if (fault_clr && !any_fault) nxt = S_IDLE;
            default:      nxt = S_FAULT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= S_IDLE;
         cnt           <= '0;
         close_q       <= 1'b0;
         precharge_en  <= 1'b0;
         main_neg_en   <= 1'b0;
         main_pos_en   <= 1'b0;
         fault_latched <= 1'b0;
         fault_code    <= '0;
      end else begin
         st      <= nxt;
         close_q <= close_req;
         if (nxt != st)
            cnt <= '0;
         else if (cnt != 24'hFFFFFF)
            cnt <= cnt + 24'd1;
         // Enables follow the next state so they change on the same edge.
         case (nxt)
            S_PRECHARGE:  {precharge_en, main_neg_en, main_pos_en} <= 3'b110;
            S_MAIN_CLOSE: {precharge_en, main_neg_en, main_pos_en} <= 3'b111;
            S_CLOSED:     {precharge_en, main_neg_en, main_pos_en} <= 3'b011;
            default:      {precharge_en, main_neg_en, main_pos_en} <= 3'b000;
         endcase
         fault_latched <= (nxt == S_FAULT);
         if (nxt == S_FAULT)
            fault_code <= fault_code | fault_bits;
         else if (st == S_FAULT)
            fault_code <= '0;
      end
   end

endmodule

// File: tb/tb_bms_contactor_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_bms_contactor_ctrl;
   localparam int PMIN = 4, PTO = 10, POV = 3;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       wd_fault = 0, ov_fault = 0, uv_fault = 0, ot_fault = 0;
   logic       close_req = 0, fault_clr = 0, precharge_ok = 0;
   logic       precharge_en, main_neg_en, main_pos_en, fault_latched;
   logic [2:0] state;
   logic [3:0] fault_code;

   int checks = 0, errors = 0;

   bms_contactor_ctrl #(
      .PRECHARGE_MIN(24'd4), .PRECHARGE_TIMEOUT(24'd10), .OVERLAP_CYCLES(24'd3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wd_fault(wd_fault), .ov_fault(ov_fault),
      .uv_fault(uv_fault), .ot_fault(ot_fault), .close_req(close_req),
      .fault_clr(fault_clr), .precharge_ok(precharge_ok),
      .precharge_en(precharge_en), .main_neg_en(main_neg_en), .main_pos_en(main_pos_en),
      .state(state), .fault_latched(fault_latched), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   // Model: mode 0 idle, 1 precharging, 2 overlap, 3 connected, 4 tripped.
   int       m_mode = 0, m_age = 0;
   logic [3:0] m_code = 0;
   bit       m_prev_close = 0;

   function automatic logic [2:0] drive_of(input int mode);
      logic [2:0] tbl [5];
      tbl = '{3'b000, 3'b110, 3'b111, 3'b011, 3'b000};
      return tbl[mode];
   endfunction

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_code = 0; m_prev_close = 0;
   endtask

   task automatic model_step();
      int  old;
      bit  any, tmo;
      logic [3:0] bits;
      old  = m_mode;
      any  = wd_fault || ov_fault || uv_fault || ot_fault;
      tmo  = (m_mode == 1) && (m_age == PTO - 1);
      bits = {tmo, ot_fault, ov_fault || uv_fault, wd_fault};
      if ((m_mode != 4 && any) || tmo) begin
         m_mode = 4; m_code |= bits;
      end else if (!close_req && m_mode >= 1 && m_mode <= 3) m_mode = 0;
      else if (m_mode == 0 && close_req && !m_prev_close) m_mode = 1;
      else if (m_mode == 1 && precharge_ok && m_age >= PMIN - 1) m_mode = 2;
      else if (m_mode == 2 && m_age == POV - 1) m_mode = 3;
      else if (m_mode == 4) begin
         m_code |= bits;
         if (fault_clr && !any) begin m_mode = 0; m_code = 0; end
      end
      m_age = (m_mode != old) ? 0 : m_age + 1;
      m_prev_close = close_req;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_model();
      chk("state_vs_model", state, m_mode);
      chk("enables_vs_model", {precharge_en, main_neg_en, main_pos_en}, drive_of(m_mode));
      chk("latched_vs_model", fault_latched, m_mode == 4);
      chk("code_vs_model", fault_code, m_code);
   endtask

   // Drive at negedge, model advances at posedge, compare at next negedge.
   task automatic cyc(input bit cr, input bit ok, input bit wd, input bit ov,
                      input bit uv, input bit ot, input bit clr);
      close_req = cr; precharge_ok = ok; wd_fault = wd; ov_fault = ov;
      uv_fault = uv; ot_fault = ot; fault_clr = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic idle_in(input bit cr, input bit ok);
      cyc(cr, ok, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", state, 0);
      chk("reset_enables", {precharge_en, main_neg_en, main_pos_en}, 0);
      chk("reset_code", fault_code, 0);
      chk("reset_latched", fault_latched, 0);
      rst_n = 1'b1;

      // Normal close
      idle_in(1, 0);
      chk("pc_enter", state, 1);
      chk("pc_enables", {precharge_en, main_neg_en, main_pos_en}, 3'b110);
      idle_in(1, 0);
      idle_in(1, 1);
      idle_in(1, 1);
      chk("pc_min_hold", state, 1);
      idle_in(1, 1);
      chk("mc_enter", state, 2);
      chk("mc_enables", {precharge_en, main_neg_en, main_pos_en}, 3'b111);
      idle_in(1, 1);
      idle_in(1, 1);
      chk("mc_hold", state, 2);
      idle_in(1, 1);
      chk("closed_state", state, 3);
      chk("closed_enables", {precharge_en, main_neg_en, main_pos_en}, 3'b011);
      chk("closed_code", fault_code, 0);

      // Watchdog pulse while closed
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("wd_state", state, 4);
      chk("wd_enables", {precharge_en, main_neg_en, main_pos_en}, 0);
      chk("wd_code", fault_code, 4'b0001);
      idle_in(1, 0);
      chk("wd_code_held", fault_code, 4'b0001);

      // Clear rules
      cyc(1, 0, 0, 0, 0, 1, 1);
      chk("clr_ignored", state, 4);
      chk("clr_ignored_code", fault_code, 4'b0101);
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("clr_ok_state", state, 0);
      chk("clr_ok_code", fault_code, 0);
      idle_in(1, 0);
      idle_in(1, 0);
      chk("no_autoreclose", state, 0);
      idle_in(0, 0);
      idle_in(1, 0);
      chk("reclose_after_toggle", state, 1);

      // ov+uv with close_req falling in precharge
      cyc(0, 0, 0, 1, 1, 0, 0);
      chk("simul_state", state, 4);
      chk("simul_code", fault_code, 4'b0010);
      cyc(0, 0, 0, 0, 0, 0, 1);

      // Precharge timeout
      idle_in(1, 0);
      for (int i = 0; i < PTO - 1; i++) idle_in(1, 0);
      chk("pre_timeout_state", state, 1);
      idle_in(1, 0);
      chk("timeout_state", state, 4);
      chk("timeout_code", fault_code, 4'b1000);
      chk("timeout_enables", {precharge_en, main_neg_en, main_pos_en}, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);

      // Async reset in MAIN_CLOSE
      for (int i = 0; i < PMIN + 1; i++) idle_in(1, 1);
      chk("mc_before_reset", state, 2);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_enables", {precharge_en, main_neg_en, main_pos_en}, 0);
      chk("async_state", state, 0);
      chk("async_code", fault_code, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_in(0, 0);

      // Randomized traffic against the model
      begin
         bit cr = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cr = ~cr;
            cyc(cr, $urandom_range(0, 1) == 1,
                $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 7) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
